// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: owner encoding, default geometry
// and the width rule for the burst-hold counter.
package dmem_arb_pkg;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_M0   = 2'd1;
    localparam logic [1:0] OWN_M1   = 2'd2;

    localparam int AW_DEF       = 8;
    localparam int DW_DEF       = 16;
    localparam int MAX_HOLD_DEF = 4;

    function automatic int hold_width(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_resp.sv
// Per-master read response: captures asynchronous memory read data at the end of a
// granted read and flags it valid for exactly the following cycle.
module dmem_arb_resp
    import dmem_arb_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          gnt,
    input  logic          we,
    input  logic [DW-1:0] mem_rdata,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);

    logic          rvalid_d;
    logic          rvalid_q;
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    // Next-state: capture on a granted read, otherwise hold the last read value
    always_comb begin
        rvalid_d = gnt & ~we;
        if (rvalid_d) begin
            rdata_d = mem_rdata;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= {DW{1'b0}};
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter with bounded burst lock in front of the single-port
// data memory; drives the memory pins and returns registered read data.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_ena,
    output logic          mem_wena,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            HW         = hold_width(MAX_HOLD);
    localparam logic [HW:0]   MAX_HOLD_W = (HW + 1)'(MAX_HOLD);

    logic [1:0]    owner_d, owner_q;
    logic          last_gnt_d, last_gnt_q;
    logic [HW-1:0] hold_cnt_d, hold_cnt_q;
    logic [HW:0]   hold_inc_s;
    logic          gnt0_s, gnt1_s;

    // Grant selection: the owner has priority, otherwise round-robin on a tie
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        case (owner_q)
            OWN_M0: gnt0_s = m0_req;
            OWN_M1: gnt1_s = m1_req;
            OWN_NONE: begin
                if (m0_req && m1_req) begin
                    gnt0_s = last_gnt_q;
                    gnt1_s = ~last_gnt_q;
                end else begin
                    gnt0_s = m0_req;
                    gnt1_s = m1_req;
                end
            end
            default: begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        endcase
    end

    // Grants are suppressed combinationally while reset is held
    assign m0_gnt = gnt0_s & rst_n;
    assign m1_gnt = gnt1_s & rst_n;

    // Ownership update; any cycle without a grant releases the memory
    always_comb begin
        owner_d    = OWN_NONE;
        hold_cnt_d = {HW{1'b0}};
        last_gnt_d = last_gnt_q;
        hold_inc_s = {1'b0, hold_cnt_q} + {{HW{1'b0}}, 1'b1};
        if (m0_gnt) begin
            last_gnt_d = 1'b0;
            if (m0_lock && (hold_inc_s < MAX_HOLD_W)) begin
                owner_d    = OWN_M0;
                hold_cnt_d = hold_inc_s[HW-1:0];
            end else begin
                owner_d    = OWN_NONE;
                hold_cnt_d = {HW{1'b0}};
            end
        end else if (m1_gnt) begin
            last_gnt_d = 1'b1;
            if (m1_lock && (hold_inc_s < MAX_HOLD_W)) begin
                owner_d    = OWN_M1;
                hold_cnt_d = hold_inc_s[HW-1:0];
            end else begin
                owner_d    = OWN_NONE;
                hold_cnt_d = {HW{1'b0}};
            end
        end else begin
            owner_d    = OWN_NONE;
            hold_cnt_d = {HW{1'b0}};
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_NONE;
            last_gnt_q <= 1'b1;
            hold_cnt_q <= {HW{1'b0}};
        end else begin
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Memory pin mux: idle pins are driven to zero
    always_comb begin
        mem_ena   = 1'b0;
        mem_wena  = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        if (m0_gnt) begin
            mem_ena   = 1'b1;
            mem_wena  = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_ena   = 1'b1;
            mem_wena  = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end else begin
            mem_ena   = 1'b0;
            mem_wena  = 1'b0;
            mem_addr  = {AW{1'b0}};
            mem_wdata = {DW{1'b0}};
        end
    end

    dmem_arb_resp #(.DW(DW)) u_resp_m0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .gnt       (m0_gnt),
        .we        (m0_we),
        .mem_rdata (mem_rdata),
        .rvalid    (m0_rvalid),
        .rdata     (m0_rdata)
    );

    dmem_arb_resp #(.DW(DW)) u_resp_m1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .gnt       (m1_gnt),
        .we        (m1_we),
        .mem_rdata (mem_rdata),
        .rvalid    (m1_rvalid),
        .rdata     (m1_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a 256x16 memory model, a rule-level reference model of the
// arbitration, directed sequences, a grant table and a randomized phase.
module tb_dmem_arbiter;

    localparam int AW       = 8;
    localparam int DW       = 16;
    localparam int MAX_HOLD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_ena, mem_wena;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    // Memory model with a bench-only init port
    logic [DW-1:0] mem_array [256];
    logic          init_we;
    logic [AW-1:0] init_addr;
    logic [DW-1:0] init_data;

    // Reference model state
    int            m_owner, m_last, m_beats, m_win;
    logic          m_rvalid [2];
    logic [DW-1:0] m_rdata  [2];
    logic [DW-1:0] shadow   [256];
    int            n_cmp, n_bad;

    // Randomized stimulus holding registers
    logic          s_r0, s_w0, s_l0, s_r1, s_w1, s_l1;
    logic [AW-1:0] s_a0, s_a1;
    logic [DW-1:0] s_d0, s_d1;

    typedef struct {
        logic r0; logic w0; logic l0; logic [7:0] a0; logic [15:0] d0;
        logic r1; logic w1; logic l1; logic [7:0] a1; logic [15:0] d1;
        logic g0; logic g1;
    } vec_t;
    vec_t tbl [19];

    always #5 clk = ~clk;

    assign mem_rdata = mem_array[mem_addr];

    always @(posedge clk) begin
        if (init_we) mem_array[init_addr] <= init_data;
        else if (mem_ena && mem_wena) mem_array[mem_addr] <= mem_wdata;
    end

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_ena(mem_ena), .mem_wena(mem_wena), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 257) ^ 16'hA5C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic l0, input logic [7:0] a0,
                         input logic [15:0] d0, input logic r1, input logic w1, input logic l1,
                         input logic [7:0] a1, input logic [15:0] d1);
        m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_beats = 0; m_win = -1;
        m_rvalid[0] = 1'b0; m_rvalid[1] = 1'b0;
        m_rdata[0] = 16'h0000; m_rdata[1] = 16'h0000;
    endtask

    // Settle inputs, predict the winner from the rules and check the combinational outputs
    task automatic comb_phase(input string tag);
        int win;
        logic ew;
        logic [7:0] ea;
        logic [15:0] ed;
        #2;
        if (m_owner == 0)                win = m0_req ? 0 : -1;
        else if (m_owner == 1)           win = m1_req ? 1 : -1;
        else if (m0_req && m1_req)       win = 1 - m_last;
        else if (m0_req)                 win = 0;
        else if (m1_req)                 win = 1;
        else                             win = -1;
        m_win = win;
        ew = (win == 0) ? m0_we    : (win == 1) ? m1_we    : 1'b0;
        ea = (win == 0) ? m0_addr  : (win == 1) ? m1_addr  : 8'h00;
        ed = (win == 0) ? m0_wdata : (win == 1) ? m1_wdata : 16'h0000;
        chk({tag, ".gnt0"},      32'(m0_gnt),    32'(win == 0));
        chk({tag, ".gnt1"},      32'(m1_gnt),    32'(win == 1));
        chk({tag, ".mem_ena"},   32'(mem_ena),   32'(win >= 0));
        chk({tag, ".mem_wena"},  32'(mem_wena),  32'(ew));
        chk({tag, ".mem_addr"},  32'(mem_addr),  32'(ea));
        chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(ed));
    endtask

    // Clock edge: apply the access to the model memory, update ownership, check responses
    task automatic edge_phase(input string tag);
        logic lk;
        @(posedge clk);
        lk = 1'b0;
        m_rvalid[0] = 1'b0;
        m_rvalid[1] = 1'b0;
        if (m_win == 0) begin
            if (m0_we) shadow[m0_addr] = m0_wdata;
            else begin m_rvalid[0] = 1'b1; m_rdata[0] = shadow[m0_addr]; end
            lk = m0_lock;
        end else if (m_win == 1) begin
            if (m1_we) shadow[m1_addr] = m1_wdata;
            else begin m_rvalid[1] = 1'b1; m_rdata[1] = shadow[m1_addr]; end
            lk = m1_lock;
        end
        if (m_win >= 0) begin
            m_last = m_win;
            if (lk && (m_beats + 1 < MAX_HOLD)) begin m_owner = m_win; m_beats++; end
            else begin m_owner = -1; m_beats = 0; end
        end else begin
            m_owner = -1; m_beats = 0;
        end
        #1;
        chk({tag, ".rvalid0"}, 32'(m0_rvalid), 32'(m_rvalid[0]));
        chk({tag, ".rvalid1"}, 32'(m1_rvalid), 32'(m_rvalid[1]));
        chk({tag, ".rdata0"},  32'(m0_rdata),  32'(m_rdata[0]));
        chk({tag, ".rdata1"},  32'(m1_rdata),  32'(m_rdata[1]));
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        model_reset();
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        init_we = 1'b0; init_addr = 8'h00; init_data = 16'h0000;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        model_reset();

        // Fill memory while reset is held
        #1;
        init_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            init_addr = 8'(i); init_data = pat(i); shadow[i] = pat(i);
            @(posedge clk);
            #1;
        end
        init_we = 1'b0;
        chk("rst.gnt0", 32'(m0_gnt), 32'd0);
        chk("rst.gnt1", 32'(m1_gnt), 32'd0);
        chk("rst.mem_ena", 32'(mem_ena), 32'd0);
        chk("rst.rvalid0", 32'(m0_rvalid), 32'd0);
        chk("rst.rdata1", 32'(m1_rdata), 32'd0);
        rst_n = 1'b1;

        // m0 write 0x10 then m1 reads it back
        drive(1'b1, 1'b1, 1'b0, 8'h10, 16'hBEEF, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        comb_phase("wr10");
        chk("wr10.gnt0_direct", 32'(m0_gnt), 32'd1);
        chk("wr10.wena_direct", 32'(mem_wena), 32'd1);
        edge_phase("wr10");
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0000);
        comb_phase("rd10");
        edge_phase("rd10");
        chk("rd10.rvalid1_direct", 32'(m1_rvalid), 32'd1);
        chk("rd10.rdata1_direct", 32'(m1_rdata), 32'h0000BEEF);

        // Top-address write/read, address 0x00 untouched
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        comb_phase("wrFF");
        edge_phase("wrFF");
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        comb_phase("rdFF");
        chk("rdFF.addr_direct", 32'(mem_addr), 32'h000000FF);
        edge_phase("rdFF");
        chk("rdFF.rdata0_direct", 32'(m0_rdata), 32'h0000FFFF);
        chk("addr00.untouched", 32'(mem_array[0]), 32'(pat(0)));

        // Reset during an m1 locked read burst
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h20, 16'h0000);
        comb_phase("burst20"); edge_phase("burst20");
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h21, 16'h0000);
        comb_phase("burst21"); edge_phase("burst21");
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h22, 16'h0000);
        comb_phase("burst22");
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.gnt1", 32'(m1_gnt), 32'd0);
        chk("midrst.mem_ena", 32'(mem_ena), 32'd0);
        chk("midrst.rvalid1", 32'(m1_rvalid), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst.rvalid1_edge", 32'(m1_rvalid), 32'd0);
        chk("midrst.rdata1_edge", 32'(m1_rdata), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'h23, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h23, 16'h0000);
        comb_phase("postrst");
        chk("postrst.gnt0_direct", 32'(m0_gnt), 32'd1);
        chk("postrst.gnt1_direct", 32'(m1_gnt), 32'd0);
        edge_phase("postrst");

        // Grant table: alternation, m1 burst, owner drop, m0 burst after counter clear
        do_reset(2);
        tbl[0]  = '{1'b1,1'b0,1'b0,8'h30,16'h0000, 1'b1,1'b0,1'b0,8'h40,16'h0000, 1'b1,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b0,8'h31,16'h0000, 1'b1,1'b0,1'b0,8'h41,16'h0000, 1'b0,1'b1};
        tbl[2]  = '{1'b1,1'b0,1'b0,8'h32,16'h0000, 1'b1,1'b0,1'b0,8'h42,16'h0000, 1'b1,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b0,8'h33,16'h0000, 1'b1,1'b0,1'b0,8'h43,16'h0000, 1'b0,1'b1};
        tbl[4]  = '{1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b1,1'b1,8'h50,16'h1111, 1'b0,1'b1};
        tbl[5]  = '{1'b1,1'b0,1'b0,8'h34,16'h0000, 1'b1,1'b1,1'b1,8'h51,16'h2222, 1'b0,1'b1};
        tbl[6]  = '{1'b1,1'b0,1'b0,8'h34,16'h0000, 1'b1,1'b1,1'b1,8'h52,16'h3333, 1'b0,1'b1};
        tbl[7]  = '{1'b1,1'b0,1'b0,8'h34,16'h0000, 1'b1,1'b0,1'b1,8'h50,16'h0000, 1'b0,1'b1};
        tbl[8]  = '{1'b1,1'b0,1'b0,8'h34,16'h0000, 1'b1,1'b0,1'b1,8'h51,16'h0000, 1'b1,1'b0};
        tbl[9]  = '{1'b1,1'b1,1'b1,8'h60,16'hAAAA, 1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0};
        tbl[10] = '{1'b1,1'b0,1'b1,8'h60,16'h0000, 1'b1,1'b0,1'b0,8'h52,16'h0000, 1'b1,1'b0};
        tbl[11] = '{1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0,1'b0,8'h52,16'h0000, 1'b0,1'b0};
        tbl[12] = '{1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0,1'b0,8'h52,16'h0000, 1'b0,1'b1};
        tbl[13] = '{1'b1,1'b0,1'b1,8'h61,16'h0000, 1'b0,1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0};
        tbl[14] = '{1'b1,1'b0,1'b1,8'h62,16'h0000, 1'b1,1'b0,1'b0,8'h53,16'h0000, 1'b1,1'b0};
        tbl[15] = '{1'b1,1'b0,1'b1,8'h63,16'h0000, 1'b1,1'b0,1'b0,8'h53,16'h0000, 1'b1,1'b0};
        tbl[16] = '{1'b1,1'b0,1'b1,8'h64,16'h0000, 1'b1,1'b0,1'b0,8'h53,16'h0000, 1'b1,1'b0};
        tbl[17] = '{1'b1,1'b0,1'b1,8'h65,16'h0000, 1'b1,1'b0,1'b0,8'h53,16'h0000, 1'b0,1'b1};
        tbl[18] = '{1'b1,1'b0,1'b0,8'h65,16'h0000, 1'b1,1'b0,1'b0,8'h54,16'h0000, 1'b1,1'b0};
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].r0, tbl[i].w0, tbl[i].l0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].l1, tbl[i].a1, tbl[i].d1);
            comb_phase($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.g0_table", i), 32'(m0_gnt), 32'(tbl[i].g0));
            chk($sformatf("tbl%0d.g1_table", i), 32'(m1_gnt), 32'(tbl[i].g1));
            edge_phase($sformatf("tbl%0d", i));
        end

        // Randomized traffic; an ungranted request is held unchanged
        s_r0 = 1'b0; s_r1 = 1'b0;
        s_w0 = 1'b0; s_w1 = 1'b0; s_l0 = 1'b0; s_l1 = 1'b0;
        s_a0 = 8'h00; s_a1 = 8'h00; s_d0 = 16'h0000; s_d1 = 16'h0000;
        for (int i = 0; i < 400; i++) begin
            if (!s_r0 || m_win == 0) begin
                s_r0 = ($urandom_range(0, 3) != 0);
                s_w0 = 1'($urandom_range(0, 1));
                s_l0 = 1'($urandom_range(0, 1));
                s_a0 = 8'($urandom_range(0, 255));
                s_d0 = 16'($urandom);
            end
            if (!s_r1 || m_win == 1) begin
                s_r1 = ($urandom_range(0, 3) != 0);
                s_w1 = 1'($urandom_range(0, 1));
                s_l1 = 1'($urandom_range(0, 1));
                s_a1 = 8'($urandom_range(0, 255));
                s_d1 = 16'($urandom);
            end
            drive(s_r0, s_w0, s_l0, s_a0, s_d0, s_r1, s_w1, s_l1, s_a1, s_d1);
            comb_phase("rnd");
            edge_phase("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
